// File: rtl/fifo_stream_reader_if.sv
// Bus bundle between the read-side drain engine and its FIFO and stream neighbours.
// The master modport is the reader itself; the slave modport is the environment around it.
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) ();
  logic                  enable;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [CNT_WIDTH-1:0]  word_cnt;
  logic                  busy;

  modport master (
    input  enable,
    input  empty,
    input  rd_data,
    input  m_ready,
    output r_en,
    output m_data,
    output m_valid,
    output word_cnt,
    output busy
  );

  modport slave (
    output enable,
    output empty,
    output rd_data,
    output m_ready,
    input  r_en,
    input  m_data,
    input  m_valid,
    input  word_cnt,
    input  busy
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-domain drain engine: pops the FIFO into a 2-entry skid buffer and presents it on a
// valid/ready stream with a running count of delivered words.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 i_rclk,
  input  logic                 i_rrst,
  fifo_stream_reader_if.master io_rd
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e                r_state;
  logic                  r_busy;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [CNT_WIDTH-1:0]  r_word_cnt;

  logic       w_pop;
  logic       w_ren;
  logic [1:0] w_level;

  assign w_pop = (r_occ != 2'd0) & io_rd.m_ready;
  // occ + inflight never exceeds 2, and pop implies occ >= 1, so 2 bits cannot wrap.
  assign w_level = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_ren = (r_state == StRun) & io_rd.enable & ~io_rd.empty & (w_level < 2'd2);

  assign io_rd.r_en     = w_ren;
  assign io_rd.m_valid  = (r_occ != 2'd0);
  assign io_rd.m_data   = r_buf0;
  assign io_rd.word_cnt = r_word_cnt;
  assign io_rd.busy     = r_busy;

  always_ff @(posedge i_rclk or posedge i_rrst) begin
    if (i_rrst) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (io_rd.enable) begin
            r_state <= StRun;
            r_busy  <= 1'b1;
          end
        end
        StRun: begin
          if (!io_rd.enable) r_state <= StFlush;
        end
        StFlush: begin
          if (io_rd.enable) begin
            r_state <= StRun;
          end else if ((r_occ == 2'd0) && !r_inflight) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Head always lives in r_buf0; a pop shifts r_buf1 forward.
  always_ff @(posedge i_rclk or posedge i_rrst) begin
    if (i_rrst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_inflight <= w_ren;
      if (w_pop) r_word_cnt <= r_word_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= io_rd.rd_data;
          else               r_buf1 <= io_rd.rd_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= io_rd.rd_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= io_rd.rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: queue-based reference model plus FIFO source,
// run against a default-width instance and a 4-bit-counter instance side by side.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       empty;
  logic       m_ready;
  logic [7:0] rd_data;
  bit         force_empty;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus  ();
  fifo_stream_reader_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  bus4 ();

  assign bus.enable   = enable;
  assign bus.empty    = empty;
  assign bus.rd_data  = rd_data;
  assign bus.m_ready  = m_ready;
  assign bus4.enable  = enable;
  assign bus4.empty   = empty;
  assign bus4.rd_data = rd_data;
  assign bus4.m_ready = m_ready;

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .i_rclk (clk),
    .i_rrst (rst),
    .io_rd  (bus.master)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .i_rclk (clk),
    .i_rrst (rst),
    .io_rd  (bus4.master)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=idle 1=run 2=flush, buffer as a queue, one in-flight flag.
  int         mode;
  logic [7:0] mbuf[$];
  bit         minfl;
  int         mcnt;
  logic [7:0] src[$];
  logic [7:0] sent[$];
  logic [7:0] got[$];
  int         ren_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] w);
    src.push_back(w);
    sent.push_back(w);
  endtask

  task automatic chk_order(input string tag);
    for (int i = 0; i < got.size(); i++) begin
      if (i < sent.size()) chk(tag, {24'd0, got[i]}, {24'd0, sent[i]});
      else chk(tag, 32'd1, 32'd0);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance model and FIFO source past the edge.
  task automatic step();
    bit         e_valid;
    bit         e_pop;
    bit         e_ren;
    int         lvl;
    bit         d_ren;
    bit         d_pop;
    logic [7:0] d_data;
    empty = force_empty || (src.size() == 0);
    #2;
    e_valid = (mbuf.size() != 0);
    e_pop   = e_valid && m_ready;
    lvl     = mbuf.size() + int'(minfl) - int'(e_pop);
    e_ren   = (mode == 1) && enable && !empty && (lvl < 2);
    chk("r_en", {31'd0, bus.r_en}, {31'd0, e_ren});
    chk("r_en_w4", {31'd0, bus4.r_en}, {31'd0, e_ren});
    chk("r_en_while_empty", {31'd0, bus.r_en & empty}, 32'd0);
    chk("m_valid", {31'd0, bus.m_valid}, {31'd0, e_valid});
    if (e_valid) chk("m_data", {24'd0, bus.m_data}, {24'd0, mbuf[0]});
    chk("word_cnt", {16'd0, bus.word_cnt}, mcnt % 65536);
    chk("word_cnt_w4", {28'd0, bus4.word_cnt}, mcnt % 16);
    chk("busy", {31'd0, bus.busy}, {31'd0, (mode != 0)});
    d_ren  = bus.r_en;
    d_pop  = bus.m_valid && m_ready;
    d_data = bus.m_data;
    @(posedge clk);
    #1;
    if (d_pop) got.push_back(d_data);
    if (d_ren) ren_count++;
    case (mode)
      0: if (enable) mode = 1;
      1: if (!enable) mode = 2;
      default: begin
        if (enable) mode = 1;
        else if (mbuf.size() == 0 && !minfl) mode = 0;
      end
    endcase
    if (e_pop) begin
      void'(mbuf.pop_front());
      mcnt++;
    end
    if (minfl) mbuf.push_back(rd_data);
    minfl = e_ren;
    if (d_ren && src.size() > 0) rd_data = src.pop_front();
  endtask

  // Called just after a rising edge; checks the asynchronous clear before any further edge.
  task automatic do_reset();
    empty = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_r_en", {31'd0, bus.r_en}, 32'd0);
    chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, bus.m_data}, 32'd0);
    chk("rst_word_cnt", {16'd0, bus.word_cnt}, 32'd0);
    chk("rst_word_cnt_w4", {28'd0, bus4.word_cnt}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #2;
    chk("rst_hold_r_en", {31'd0, bus.r_en}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 0;
    mbuf.delete();
    minfl = 1'b0;
    mcnt = 0;
    src.delete();
    sent.delete();
    got.delete();
    ren_count = 0;
    rd_data = 8'h00;
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b1;
    m_ready = 1'b1;
    force_empty = 1'b0;
    rd_data = 8'h00;
    empty = 1'b0;

    // Straight-through stream of four words.
    do_reset();
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    repeat (8) step();
    chk("stream_ren_count", ren_count, 4);
    chk("stream_delivered", got.size(), 4);
    chk("stream_word_cnt", {16'd0, bus.word_cnt}, 32'd4);
    chk_order("stream_order");

    // Downstream stall: buffer fills to two and pops stop.
    do_reset();
    m_ready = 1'b0;
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    repeat (8) step();
    chk("stall_ren_count", ren_count, 2);
    chk("stall_head_held", {24'd0, bus.m_data}, 32'h11);
    m_ready = 1'b1;
    repeat (8) step();
    chk("stall_delivered", got.size(), 4);
    chk_order("stall_order");

    // Enable dropped right after the first pop: in-flight word still delivered, then idle.
    do_reset();
    for (int i = 0; i < 5; i++) load(8'(8'hA0 + i));
    step();
    step();
    enable = 1'b0;
    step();
    chk("flush_busy", {31'd0, bus.busy}, 32'd1);
    repeat (5) step();
    chk("flush_delivered", got.size(), 1);
    chk("flush_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk_order("flush_order");
    enable = 1'b1;

    // Empty toggling every cycle with random downstream backpressure.
    do_reset();
    for (int i = 0; i < 20; i++) load(8'($urandom));
    for (int c = 0; c < 400 && got.size() < 20; c++) begin
      force_empty = !force_empty;
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    force_empty = 1'b0;
    m_ready = 1'b1;
    chk("rand_delivered", got.size(), 20);
    chk_order("rand_order");

    // Counter wrap on the 4-bit instance, then reset in the middle of a burst.
    do_reset();
    for (int i = 0; i < 17; i++) load(8'($urandom));
    for (int c = 0; c < 60 && got.size() < 17; c++) step();
    chk("wrap_delivered", got.size(), 17);
    chk("wrap_word_cnt_w4", {28'd0, bus4.word_cnt}, 32'd1);
    chk("wrap_word_cnt", {16'd0, bus.word_cnt}, 32'd17);
    for (int i = 0; i < 6; i++) load(8'($urandom));
    repeat (4) step();
    chk("burst_valid", {31'd0, bus.m_valid}, 32'd1);
    do_reset();
    enable = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
